// File: rtl/mips_ctrl_fetch_if.sv
// Bus between the control/fetch slice and the rest of the single-cycle MIPS datapath.
// The master side is the control/fetch block; the slave side is the datapath that feeds it.
interface mips_ctrl_fetch_if;
    logic [31:0] instr;
    logic        Zero;
    logic [31:0] ra;
    logic [31:0] PC;
    logic [1:0]  PCWr;
    logic [31:0] Imm32;
    logic [1:0]  jump;
    logic [1:0]  Branch;
    logic        RegDst;
    logic        MemR;
    logic        Mem2R;
    logic        MemW;
    logic        RegW;
    logic        Alusrc;
    logic [1:0]  EXTOp;
    logic [4:0]  Aluctrl;

    modport master (
        input  instr, Zero, ra,
        output PC, PCWr, Imm32, jump, Branch, RegDst, MemR, Mem2R, MemW,
               RegW, Alusrc, EXTOp, Aluctrl
    );

    modport slave (
        output instr, Zero, ra,
        input  PC, PCWr, Imm32, jump, Branch, RegDst, MemR, Mem2R, MemW,
               RegW, Alusrc, EXTOp, Aluctrl
    );
endinterface

// File: rtl/mips_ctrl_fetch.sv
// PC register, next-PC select, main decoder and immediate extender of the single-cycle MIPS core.
// Define CTRL_SHIFT_EN to decode the R-type sll/srl/sra shifts; otherwise they decode as unlisted.
module mips_ctrl_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    mips_ctrl_fetch_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_NOR   = 5'd5;
    localparam logic [4:0] ALU_SLT   = 5'd6;
    localparam logic [4:0] ALU_SLTU  = 5'd7;
    localparam logic [4:0] ALU_SLL   = 5'd8;
    localparam logic [4:0] ALU_SRL   = 5'd9;
    localparam logic [4:0] ALU_SRA   = 5'd10;
    localparam logic [4:0] ALU_PASSB = 5'd11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;
    localparam logic [1:0] EXT_BR   = 2'b11;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JR   = 2'b11;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    // Branch offsets use sign-ext<<2 so PC+4+Imm32 lands on a word address directly.
    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic [1:0] mode);
        logic signed [31:0] simm;
        simm = 32'(signed'(imm));
        case (mode)
            EXT_ZERO: ext_imm = {16'h0000, imm};
            EXT_SIGN: ext_imm = simm;
            EXT_HI:   ext_imm = {imm, 16'h0000};
            default:  ext_imm = 32'(simm <<< 2);
        endcase
    endfunction

    logic [31:0] pc_p0;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] imm32;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [1:0]  pcwr;
    logic [1:0]  jump;
    logic [1:0]  branch;
    logic        regdst;
    logic        memr;
    logic        mem2r;
    logic        memw;
    logic        regw;
    logic        alusrc;
    logic [1:0]  extop;
    logic [4:0]  aluctrl;
    logic        r_hit;
    logic [4:0]  r_alu;

    assign op    = bus.instr[31:26];
    assign funct = bus.instr[5:0];

    always_comb begin
        r_hit = 1'b0;
        r_alu = ALU_ADD;
        case (funct)
            FN_ADD, FN_ADDU: begin r_hit = 1'b1; r_alu = ALU_ADD;  end
            FN_SUB, FN_SUBU: begin r_hit = 1'b1; r_alu = ALU_SUB;  end
            FN_AND:          begin r_hit = 1'b1; r_alu = ALU_AND;  end
            FN_OR:           begin r_hit = 1'b1; r_alu = ALU_OR;   end
            FN_XOR:          begin r_hit = 1'b1; r_alu = ALU_XOR;  end
            FN_NOR:          begin r_hit = 1'b1; r_alu = ALU_NOR;  end
            FN_SLT:          begin r_hit = 1'b1; r_alu = ALU_SLT;  end
            FN_SLTU:         begin r_hit = 1'b1; r_alu = ALU_SLTU; end
`ifdef CTRL_SHIFT_EN
            FN_SLL:          begin r_hit = 1'b1; r_alu = ALU_SLL;  end
            FN_SRL:          begin r_hit = 1'b1; r_alu = ALU_SRL;  end
            FN_SRA:          begin r_hit = 1'b1; r_alu = ALU_SRA;  end
`else
`endif
            default:         begin r_hit = 1'b0; r_alu = ALU_ADD;  end
        endcase
    end

    always_comb begin
        jump    = JMP_NONE;
        branch  = BR_NONE;
        regdst  = 1'b0;
        memr    = 1'b0;
        mem2r   = 1'b0;
        memw    = 1'b0;
        regw    = 1'b0;
        alusrc  = 1'b0;
        extop   = EXT_ZERO;
        aluctrl = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    jump = JMP_JR;
                end else if (r_hit) begin
                    regw    = 1'b1;
                    aluctrl = r_alu;
                end
            end
            OP_ADDI, OP_ADDIU: begin
                regw = 1'b1; regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_SIGN; aluctrl = ALU_ADD;
            end
            OP_SLTI: begin
                regw = 1'b1; regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_SIGN; aluctrl = ALU_SLT;
            end
            OP_ANDI: begin
                regw = 1'b1; regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_ZERO; aluctrl = ALU_AND;
            end
            OP_ORI: begin
                regw = 1'b1; regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_ZERO; aluctrl = ALU_OR;
            end
            OP_XORI: begin
                regw = 1'b1; regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_ZERO; aluctrl = ALU_XOR;
            end
            OP_LUI: begin
                regw = 1'b1; regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_HI; aluctrl = ALU_PASSB;
            end
            OP_LW: begin
                regw = 1'b1; regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_SIGN; aluctrl = ALU_ADD;
                memr = 1'b1; mem2r = 1'b1;
            end
            OP_SW: begin
                regdst = 1'b1; alusrc = 1'b1;
                extop = EXT_SIGN; aluctrl = ALU_ADD; memw = 1'b1;
            end
            OP_BEQ: begin
                regdst = 1'b1; extop = EXT_BR; aluctrl = ALU_SUB; branch = BR_BEQ;
            end
            OP_BNE: begin
                regdst = 1'b1; extop = EXT_BR; aluctrl = ALU_SUB; branch = BR_BNE;
            end
            OP_J: begin
                regdst = 1'b1; alusrc = 1'b1; branch = BR_JMP; jump = JMP_J;
            end
            // jal writes $31 with PC+4; the datapath overrides the destination and data.
            OP_JAL: begin
                regdst = 1'b1; alusrc = 1'b1; regw = 1'b1;
                branch = BR_JMP; jump = JMP_JAL;
            end
            default: begin
                jump = JMP_NONE;
            end
        endcase
    end

    assign imm32 = ext_imm(bus.instr[15:0], extop);

    always_comb begin
        pcwr = NPC_SEQ;
        if ((branch == BR_BEQ && bus.Zero) || (branch == BR_BNE && !bus.Zero)) begin
            pcwr = NPC_BRANCH;
        end else if (branch == BR_JMP && (jump == JMP_J || jump == JMP_JAL)) begin
            pcwr = NPC_JUMP;
        end else if (jump == JMP_JR) begin
            pcwr = NPC_JR;
        end
    end

    assign pc_plus4 = pc_p0 + 32'd4;

    always_comb begin
        case (pcwr)
            NPC_SEQ:    next_pc = pc_plus4;
            NPC_BRANCH: next_pc = pc_plus4 + imm32;
            NPC_JUMP:   next_pc = {pc_plus4[31:28], bus.instr[25:0], 2'b00};
            default:    next_pc = bus.ra;
        endcase
    end

    // Stage 0: program counter, no stall path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= next_pc;
        end
    end

    assign bus.PC      = pc_p0;
    assign bus.PCWr    = pcwr;
    assign bus.Imm32   = imm32;
    assign bus.jump    = jump;
    assign bus.Branch  = branch;
    assign bus.RegDst  = regdst;
    assign bus.MemR    = memr;
    assign bus.Mem2R   = mem2r;
    assign bus.MemW    = memw;
    assign bus.RegW    = regw;
    assign bus.Alusrc  = alusrc;
    assign bus.EXTOp   = extop;
    assign bus.Aluctrl = aluctrl;

endmodule

// File: tb/tb_mips_ctrl_fetch.sv
// Scoreboard bench for mips_ctrl_fetch: each vector queues its expected decode and next PC,
// the checker pops it on the falling edge and checks PC after the following rising edge.
module tb_mips_ctrl_fetch;

`ifdef CTRL_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    // Control vector layout: {jump, Branch, RegDst, MemR, Mem2R, MemW, RegW, Alusrc, EXTOp, Aluctrl}
    localparam logic [16:0] M_ALL = 17'h1FFFF;
    localparam logic [16:0] M_BR  = 17'h1EFFF;
    localparam logic [16:0] M_J   = 17'h1EF00;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [16:0] ctl;
        logic [16:0] mask;
        bit          chkimm;
        logic [31:0] imm;
        logic [1:0]  pcwr;
        logic [31:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    exp_t        cur;

    mips_ctrl_fetch_if bus ();

    mips_ctrl_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] mk_ctl(input logic [1:0] jmp, input logic [1:0] br,
                                           input logic rd, input logic mr, input logic m2r,
                                           input logic mw, input logic rw, input logic as,
                                           input logic [1:0] ext, input logic [4:0] alu);
        mk_ctl = {jmp, br, rd, mr, m2r, mw, rw, as, ext, alu};
    endfunction

    task automatic vec(input string tag, input logic [31:0] ins, input logic z,
                       input logic [31:0] rav, input logic [16:0] ctl, input logic [16:0] mask,
                       input bit ci, input logic [31:0] imm, input logic [1:0] pw,
                       input logic [31:0] tgt);
        exp_t e;
        bus.instr = ins;
        bus.Zero  = z;
        bus.ra    = rav;
        e.tag    = tag;
        e.pc     = exp_pc;
        e.ctl    = ctl;
        e.mask   = mask;
        e.chkimm = ci;
        e.imm    = imm;
        e.pcwr   = pw;
        e.npc    = (pw == 2'b00) ? exp_pc + 32'd4 : tgt;
        exp_pc   = e.npc;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check({cur.tag, ".pc"}, bus.PC, cur.pc);
            check({cur.tag, ".ctl"},
                  32'({bus.jump, bus.Branch, bus.RegDst, bus.MemR, bus.Mem2R, bus.MemW,
                       bus.RegW, bus.Alusrc, bus.EXTOp, bus.Aluctrl} & cur.mask),
                  32'(cur.ctl & cur.mask));
            check({cur.tag, ".pcwr"}, 32'(bus.PCWr), 32'(cur.pcwr));
            if (cur.chkimm) check({cur.tag, ".imm"}, bus.Imm32, cur.imm);
            @(posedge clk);
            #1;
            check({cur.tag, ".npc"}, bus.PC, cur.npc);
        end
    end

    initial begin
        logic [16:0] c_nop;
        logic [16:0] c_r;
        c_nop = mk_ctl(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, SH, 1'b0, 2'd0, SH ? 5'd8 : 5'd0);
        c_r   = mk_ctl(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0);

        // Reset held with a jump on the bus: PC must not move.
        bus.instr = 32'h0800_0010;
        bus.Zero  = 1'b0;
        bus.ra    = 32'h0000_0024;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", bus.PC, 32'h0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;

        vec("nop0", 32'h0, 1'b0, 32'h0, c_nop, M_ALL, 1'b1, 32'h0, 2'd0, 32'h0);
        vec("nop1", 32'h0, 1'b0, 32'h0, c_nop, M_ALL, 1'b1, 32'h0, 2'd0, 32'h0);
        vec("nop2", 32'h0, 1'b0, 32'h0, c_nop, M_ALL, 1'b1, 32'h0, 2'd0, 32'h0);
        vec("ori", 32'h3401_1234, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd0, 5'd3), M_ALL, 1'b1, 32'h0000_1234, 2'd0, 32'h0);
        vec("beq_t", 32'h1000_FFFE, 1'b1, 32'h0,
            mk_ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'd3, 5'd1), M_BR, 1'b1, 32'hFFFF_FFF8, 2'd1, 32'h0C);
        vec("ori2", 32'h3401_1234, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd0, 5'd3), M_ALL, 1'b1, 32'h0000_1234, 2'd0, 32'h0);
        vec("beq_nt", 32'h1000_FFFE, 1'b0, 32'h0,
            mk_ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'd3, 5'd1), M_BR, 1'b1, 32'hFFFF_FFF8, 2'd0, 32'h0);
        vec("bne_nt", 32'h1400_0002, 1'b1, 32'h0,
            mk_ctl(0, 2, 0, 0, 0, 0, 0, 0, 2'd3, 5'd1), M_BR, 1'b1, 32'h0000_0008, 2'd0, 32'h0);
        vec("bne_t", 32'h1400_0001, 1'b0, 32'h0,
            mk_ctl(0, 2, 0, 0, 0, 0, 0, 0, 2'd3, 5'd1), M_BR, 1'b1, 32'h0000_0004, 2'd1, 32'h20);
        vec("jal", 32'h0C00_0040, 1'b0, 32'h0,
            mk_ctl(2, 3, 0, 0, 0, 0, 1, 0, 2'd0, 5'd0), M_J, 1'b0, 32'h0, 2'd2, 32'h100);
        vec("jr", 32'h03E0_0008, 1'b0, 32'h24,
            mk_ctl(3, 0, 0, 0, 0, 0, 0, 0, 2'd0, 5'd0), M_ALL, 1'b1, 32'h8, 2'd3, 32'h24);
        vec("lui", 32'h3C01_8000, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd2, 5'd11), M_ALL, 1'b1, 32'h8000_0000, 2'd0, 32'h0);
        vec("lw", 32'h8C22_0004, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 1, 1, 0, 1, 1, 2'd1, 5'd0), M_ALL, 1'b1, 32'h4, 2'd0, 32'h0);
        vec("sw", 32'hAC22_FFFC, 1'b0, 32'h0,
            mk_ctl(0, 0, 0, 0, 0, 1, 0, 1, 2'd1, 5'd0), M_BR, 1'b1, 32'hFFFF_FFFC, 2'd0, 32'h0);
        vec("beq_self", 32'h1000_FFFF, 1'b1, 32'h0,
            mk_ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'd3, 5'd1), M_BR, 1'b1, 32'hFFFF_FFFC, 2'd1, 32'h30);
        vec("unk_op", 32'hFC00_0000, 1'b1, 32'h0, 17'h0, M_ALL, 1'b1, 32'h0, 2'd0, 32'h0);
        vec("j", 32'h0800_0010, 1'b0, 32'h0,
            mk_ctl(1, 3, 0, 0, 0, 0, 0, 0, 2'd0, 5'd0), M_J, 1'b0, 32'h0, 2'd2, 32'h40);
        vec("addi", 32'h2001_FFFF, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd1, 5'd0), M_ALL, 1'b1, 32'hFFFF_FFFF, 2'd0, 32'h0);
        vec("addiu", 32'h2401_0001, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd1, 5'd0), M_ALL, 1'b1, 32'h1, 2'd0, 32'h0);
        vec("slti", 32'h2801_8000, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd1, 5'd6), M_ALL, 1'b1, 32'hFFFF_8000, 2'd0, 32'h0);
        vec("andi", 32'h3001_F00F, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd0, 5'd2), M_ALL, 1'b1, 32'h0000_F00F, 2'd0, 32'h0);
        vec("xori", 32'h3801_F00F, 1'b0, 32'h0,
            mk_ctl(0, 0, 1, 0, 0, 0, 1, 1, 2'd0, 5'd4), M_ALL, 1'b1, 32'h0000_F00F, 2'd0, 32'h0);
        vec("add",  32'h0022_1820, 1'b0, 32'h0, c_r | 17'd0, M_ALL, 1'b1, 32'h1820, 2'd0, 32'h0);
        vec("addu", 32'h0022_1821, 1'b0, 32'h0, c_r | 17'd0, M_ALL, 1'b1, 32'h1821, 2'd0, 32'h0);
        vec("sub",  32'h0022_1822, 1'b0, 32'h0, c_r | 17'd1, M_ALL, 1'b1, 32'h1822, 2'd0, 32'h0);
        vec("subu", 32'h0022_1823, 1'b0, 32'h0, c_r | 17'd1, M_ALL, 1'b1, 32'h1823, 2'd0, 32'h0);
        vec("and",  32'h0022_1824, 1'b0, 32'h0, c_r | 17'd2, M_ALL, 1'b1, 32'h1824, 2'd0, 32'h0);
        vec("or",   32'h0022_1825, 1'b0, 32'h0, c_r | 17'd3, M_ALL, 1'b1, 32'h1825, 2'd0, 32'h0);
        vec("xor",  32'h0022_1826, 1'b0, 32'h0, c_r | 17'd4, M_ALL, 1'b1, 32'h1826, 2'd0, 32'h0);
        vec("nor",  32'h0022_1827, 1'b0, 32'h0, c_r | 17'd5, M_ALL, 1'b1, 32'h1827, 2'd0, 32'h0);
        vec("slt",  32'h0022_182A, 1'b0, 32'h0, c_r | 17'd6, M_ALL, 1'b1, 32'h182A, 2'd0, 32'h0);
        vec("sltu", 32'h0022_182B, 1'b0, 32'h0, c_r | 17'd7, M_ALL, 1'b1, 32'h182B, 2'd0, 32'h0);
        vec("srl",  32'h0001_1042, 1'b0, 32'h0,
            mk_ctl(0, 0, 0, 0, 0, 0, SH, 0, 2'd0, SH ? 5'd9 : 5'd0), M_ALL, 1'b1, 32'h1042, 2'd0, 32'h0);
        vec("sra",  32'h0001_1043, 1'b0, 32'h0,
            mk_ctl(0, 0, 0, 0, 0, 0, SH, 0, 2'd0, SH ? 5'd10 : 5'd0), M_ALL, 1'b1, 32'h1043, 2'd0, 32'h0);
        vec("unk_fn", 32'h0022_183F, 1'b1, 32'h0, 17'h0, M_ALL, 1'b1, 32'h183F, 2'd0, 32'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        check("drain", 32'(sb.size()), 32'h0);

        // Asynchronous reset in the middle of a cycle, away from any clock edge.
        bus.instr = 32'h0;
        #1;
        rst = 1'b0;
        #1;
        check("async_rst", bus.PC, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held", bus.PC, 32'h0);
        #1;
        rst = 1'b1;
        exp_pc = 32'h0;
        vec("rel0", 32'h0, 1'b0, 32'h0, c_nop, M_ALL, 1'b1, 32'h0, 2'd0, 32'h0);
        vec("rel1", 32'h0, 1'b0, 32'h0, c_nop, M_ALL, 1'b1, 32'h0, 2'd0, 32'h0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        check("drain2", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_fetch.md
# mips_ctrl_fetch

Control-and-fetch slice of the single-cycle MIPS core. Combines the program counter register, the next-PC selection logic, the main opcode/funct decoder and the 16→32-bit immediate extender. It receives the fetched instruction, the ALU `Zero` flag and the register-file `$ra`/`rs` read value. It produces the current `PC`, every datapath control strobe and the extended immediate.

## Interface
- `RESET_PC`, default 32'h0000_0000: value loaded into `PC` on reset.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `instr`  in  32  current instruction.
- `Zero`  in  1  ALU result-equals-zero flag.
- `ra`  in  32  jump-register target (register value read for `jr`).
- `PC`  out  32  current instruction address.
- `PCWr`  out  2  next-PC select: 00 seq, 01 branch taken, 10 j/jal, 11 jr.
- `Imm32`  out  32  extended immediate.
- `jump`  out  2  00 none, 01 j, 10 jal, 11 jr.
- `Branch`  out  2  00 none, 01 beq, 10 bne, 11 j/jal.
- `RegDst`  out  1  1 = write rt, 0 = write rd.
- `MemR`, `Mem2R`, `MemW`, `RegW`, `Alusrc`  out  1 each  memory read, mem→reg select, memory write, register write, ALU B = `Imm32`.
- `EXTOp`  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16, 11 sign-ext<<2.
- `Aluctrl`  out  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 PASSB.

## Operation
- The decoder is purely combinational from `instr[31:26]` and `instr[5:0]`.
- Unlisted encodings decode with every strobe at 0, `jump`/`Branch`/`EXTOp` at 00 and `Aluctrl` at ADD.
- R-type (op 000000), all with `RegW`=1 and `RegDst`=0:
  - add/addu 100000/100001 → ADD; sub/subu 100010/100011 → SUB.
  - and 100100 → AND; or 100101 → OR; xor 100110 → XOR; nor 100111 → NOR.
  - slt 101010 → SLT; sltu 101011 → SLTU.
  - sll 000000 → SLL; srl 000010 → SRL; sra 000011 → SRA.
  - jr 001000: `RegW`=0, `jump`=11, `Branch`=00.
- I-type, `RegW`=1, `RegDst`=1, `Alusrc`=1 unless noted:
  - addi/addiu 001000/001001 → ADD, sign-ext; slti 001010 → SLT, sign-ext.
  - andi 001100 → AND, zero-ext; ori 001101 → OR, zero-ext; xori 001110 → XOR, zero-ext.
  - lui 001111 → PASSB, `EXTOp`=10.
  - lw 100011 → ADD, sign-ext, `MemR`=1, `Mem2R`=1.
  - sw 101011 → ADD, sign-ext, `MemW`=1, `RegW`=0.
  - beq 000100 / bne 000101: `RegW`=0, `Alusrc`=0, SUB, `EXTOp`=11, `Branch`=01/10.
  - j 000010: `Branch`=11, `jump`=01, no write.
  - jal 000011: `Branch`=11, `jump`=10, `RegW`=1 (the datapath forces dest $31 and data PC+4).
- `PCWr` priority:
  - 01 if (`Branch`=01 & `Zero`) or (`Branch`=10 & !`Zero`).
  - else 10 if `Branch`=11 and `jump` ∈ {01, 10}.
  - else 11 if `jump`=11.
  - else 00.
- Next PC, computed with 32-bit wrap-around arithmetic:
  - 00: PC+4.
  - 01: PC+4+`Imm32`.
  - 10: {(PC+4)[31:28], `instr[25:0]`, 2'b00}.
  - 11: `ra` unmodified.

## Timing
- Reset: `PC`=`RESET_PC` immediately on `rst` falling, held while `rst`=0; first fetch occurs on the cycle after `rst` rises.
- `PC` loads the next PC on every rising `clk` while `rst`=1; there is no stall input.
- All other outputs are combinational from `PC`, `instr`, `Zero`, `ra` and are valid the same cycle with zero latency.
- A not-taken branch advances by 4. A taken branch with offset 0xFFFF jumps to PC.

## Configuration
- `CTRL_SHIFT_EN` defined: sll/srl/sra decode as listed above.
- Not defined: those three funct codes decode as unlisted (all strobes 0, PC+4).

## Test plan
- Reset: hold `rst`=0 → `PC`=0 across clocks; release → PC 0, 4, 8 on successive edges with `instr`=0 (`RegW`=1 when enabled, SLL).
- ori 0x3401_1234 → `RegW`=1, `RegDst`=1, `Alusrc`=1, `EXTOp`=00, `Imm32`=0x0000_1234, `Aluctrl`=OR; lui 0x3C01_8000 → `Imm32`=0x8000_0000.
- beq at PC 0x10, imm 0xFFFE: `Zero`=1 → `PCWr`=01, next PC 0x0C; `Zero`=0 → next 0x14; bne taken only with `Zero`=0.
- jal 0x0C00_0040 at PC 0x20 → `PCWr`=10, `RegW`=1, next PC 0x100; jr 0x03E0_0008 with `ra`=0x24 → `PCWr`=11, next 0x24.
- lw 0x8C22_0004 → `MemR`=`Mem2R`=1, `Imm32`=4; sw 0xAC22_FFFC → `MemW`=1, `RegW`=0, `Imm32`=0xFFFF_FFFC.
- Unknown op 111111 → all strobes 0, `PCWr`=00; assert `rst` mid-run → `PC` returns to 0 without waiting for `clk`.
